time_edit_ctrl: RTL



---
 rtl/time_edit_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/time_edit_ctrl.sv
// rtl/time_edit_ctrl.sv - keyboard-driven HH:MM:SS field edit sequencer
// Optional AUTO_REPEAT_EN: held up/down keys auto-repeat their strobes after REPEAT_DELAY.
module time_edit_ctrl #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd25_000_000,
  parameter logic [23:0] REPEAT_RATE   = 24'd5_000_000,
  parameter logic [23:0] BLINK_DIV     = 24'd12_500_000,
  parameter logic [7:0]  TIMEOUT_TICKS = 8'd10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_left_i,
  input  logic       key_right_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       sec_tick_i,
  output logic       run_en_o,
  output logic       inc_hour_o,
  output logic       inc_min_o,
  output logic       inc_sec_o,
  output logic       dec_hour_o,
  output logic       dec_min_o,
  output logic       dec_sec_o,
  output logic [1:0] field_sel_o,
  output logic       blink_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  key_now, key_q, key_edge;
  logic [2:0]  inc_q, inc_d, dec_q, dec_d;
  logic        blink_q, blink_d;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        in_edit, lr_move, any_edge, both_ud, timeout_hit, moving, ud_ok;
  logic        rpt_up_fire, rpt_dn_fire, up_fire, dn_fire;

  // key bit order: {down, up, right, left}
  assign key_now     = {key_down_i, key_up_i, key_right_i, key_left_i};
  assign key_edge    = key_now & ~key_q;
  assign any_edge    = |key_edge;
  assign lr_move     = key_edge[0] ^ key_edge[1];
  assign in_edit     = (state_q != ST_RUN);
  assign both_ud     = key_up_i & key_down_i;
  assign timeout_hit = in_edit && sec_tick_i && !any_edge &&
                       (({1'b0, to_cnt_q} + 9'd1) >= {1'b0, TIMEOUT_TICKS});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (lr_move) state_d = ST_HOUR;
      ST_HOUR: if (lr_move) state_d = key_edge[1] ? ST_MIN : ST_RUN;
      ST_MIN:  if (lr_move) state_d = key_edge[1] ? ST_SEC : ST_HOUR;
      ST_SEC:  if (lr_move) state_d = key_edge[1] ? ST_RUN : ST_MIN;
      default: state_d = ST_RUN;
    endcase
    if (timeout_hit) state_d = ST_RUN;
  end

  assign moving  = (state_d != state_q);
  assign ud_ok   = in_edit && !moving && !both_ud;
  assign up_fire = ud_ok && (key_edge[2] || rpt_up_fire);
  assign dn_fire = ud_ok && (key_edge[3] || rpt_dn_fire);

`ifdef AUTO_REPEAT_EN
  logic [23:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_on_q, rpt_on_d, rpt_dn_q, rpt_dn_d;
  logic        rpt_held, rpt_fire;

  assign rpt_held = rpt_dn_q ? key_down_i : key_up_i;

  // Down-counter: a value of 0 or 1 fires, so a zero rate behaves like one.
  always_comb begin
    rpt_on_d  = 1'b0;
    rpt_cnt_d = 24'd0;
    rpt_dn_d  = rpt_dn_q;
    rpt_fire  = 1'b0;
    if (ud_ok) begin
      if (key_edge[2] || key_edge[3]) begin
        rpt_on_d  = 1'b1;
        rpt_dn_d  = key_edge[3];
        rpt_cnt_d = REPEAT_DELAY;
      end else if (rpt_on_q && rpt_held) begin
        rpt_on_d = 1'b1;
        if (rpt_cnt_q <= 24'd1) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = REPEAT_RATE;
        end else begin
          rpt_cnt_d = rpt_cnt_q - 24'd1;
        end
      end
    end
  end

  assign rpt_up_fire = rpt_fire && !rpt_dn_q;
  assign rpt_dn_fire = rpt_fire && rpt_dn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q <= 24'd0;
      rpt_on_q  <= 1'b0;
      rpt_dn_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_on_q  <= rpt_on_d;
      rpt_dn_q  <= rpt_dn_d;
    end
  end
`else
  logic [47:0] unused_rpt_params;
  assign unused_rpt_params = {REPEAT_DELAY, REPEAT_RATE};
  assign rpt_up_fire       = 1'b0;
  assign rpt_dn_fire       = 1'b0;
`endif

  always_comb begin
    inc_d = {up_fire && (state_q == ST_HOUR), up_fire && (state_q == ST_MIN),
             up_fire && (state_q == ST_SEC)};
    dec_d = {dn_fire && (state_q == ST_HOUR), dn_fire && (state_q == ST_MIN),
             dn_fire && (state_q == ST_SEC)};

    // Entry, adjustment and RUN all show the field solidly and restart the half-period.
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (moving || up_fire || dn_fire || !in_edit) begin
      blink_d     = 1'b1;
      blink_cnt_d = BLINK_DIV;
    end else if (blink_cnt_q <= 24'd1) begin
      blink_d     = ~blink_q;
      blink_cnt_d = BLINK_DIV;
    end else begin
      blink_cnt_d = blink_cnt_q - 24'd1;
    end

    to_cnt_d = to_cnt_q;
    if (!in_edit || moving || any_edge) begin
      to_cnt_d = 8'd0;
    end else if (sec_tick_i && (to_cnt_q != 8'hFF)) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      key_q       <= 4'd0;
      inc_q       <= 3'd0;
      dec_q       <= 3'd0;
      blink_q     <= 1'b1;
      blink_cnt_q <= 24'd0;
      to_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_now;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign run_en_o    = (state_q == ST_RUN);
  assign field_sel_o = state_q;
  assign blink_o     = blink_q;
  assign inc_hour_o  = inc_q[2];
  assign inc_min_o   = inc_q[1];
  assign inc_sec_o   = inc_q[0];
  assign dec_hour_o  = dec_q[2];
  assign dec_min_o   = dec_q[1];
  assign dec_sec_o   = dec_q[0];

endmodule
